// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin front end for a single-port sync RAM with zero-fill init
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  r0_valid,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ready,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,

  input  logic                  r1_valid,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ready,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_bank_sel,
  output logic                  ram_write_en,
  input  logic [DATA_WIDTH-1:0] ram_read_data,

  output logic                  init_done
);

  // One spare bit on the fill counter so the last-word compare can never alias after a wrap.
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_init_cnt;
  logic               r_last_grant;   // 0: r0 was granted last, 1: r1 was granted last
  logic               r_r0_rvalid;
  logic               r_r1_rvalid;
  logic               r_init_done;

  logic                  w_run;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_init_last;
  logic [ADDR_WIDTH-1:0] w_init_addr;

  assign w_run       = (r_state == ST_RUN);
  assign w_init_last = (r_init_cnt == CNT_W'(DEPTH - 1));
  assign w_init_addr = ADDR_WIDTH'(r_init_cnt);

  // A lone requester always wins; on contention the one not granted last time wins.
  assign w_gnt0 = w_run & r0_valid & (~r1_valid | r_last_grant);
  assign w_gnt1 = w_run & r1_valid & (~r0_valid | ~r_last_grant);

  assign r0_ready  = w_gnt0;
  assign r1_ready  = w_gnt1;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  // The RAM output register is shared; each requester qualifies it with its own rvalid.
  assign r0_rdata  = ram_read_data;
  assign r1_rdata  = ram_read_data;
  assign init_done = r_init_done;

  // RAM pin mux: zero-fill during init, otherwise mirror the granted request or stay idle.
  always_comb begin
    ram_bank_sel   = 1'b0;
    ram_write_en   = 1'b0;
    ram_addr       = '0;
    ram_write_data = '0;
    if (!w_run) begin
      ram_bank_sel   = 1'b1;
      ram_write_en   = 1'b1;
      ram_addr       = w_init_addr;
      ram_write_data = '0;
    end else if (w_gnt0) begin
      ram_bank_sel   = 1'b1;
      ram_write_en   = r0_write;
      ram_addr       = r0_addr;
      ram_write_data = r0_wdata;
    end else if (w_gnt1) begin
      ram_bank_sel   = 1'b1;
      ram_write_en   = r1_write;
      ram_addr       = r1_addr;
      ram_write_data = r1_wdata;
    end
  end

  // Init/run sequencing, round-robin history and the one-cycle read response pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_last_grant <= 1'b1;
      r_r0_rvalid  <= 1'b0;
      r_r1_rvalid  <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      // Grants only exist in RUN, so these stay low throughout init.
      r_r0_rvalid <= w_gnt0 & ~r0_write;
      r_r1_rvalid <= w_gnt1 & ~r1_write;

      if (w_gnt0) begin
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_last_grant <= 1'b1;
      end

      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + CNT_W'(1);
          if (w_init_last) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed-vector bench for ram_port_arbiter with a behavioural sync RAM
module tb_ram_port_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset_n;
  logic          r0_valid, r0_write, r0_ready, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_write, r1_ready, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data;
  logic          ram_bank_sel, ram_write_en;
  logic [DW-1:0] ram_read_data;
  logic          init_done;

  int n_vec;
  int n_miss;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_bank_sel(ram_bank_sel), .ram_write_en(ram_write_en),
    .ram_read_data(ram_read_data), .init_done(init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM; read_data only changes on reads.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hBAD0_0000 | 32'(i);
    ram_read_data = 32'hFFFF_FFFF;
  end
  always @(posedge clock) begin
    if (ram_bank_sel) begin
      if (ram_write_en) mem[ram_addr] <= ram_write_data;
      else              ram_read_data <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  // Called just after reset release; walks the 16 fill writes with both requesters pushing.
  task automatic init_seq();
    r0_valid = 1'b1; r1_valid = 1'b1; r0_write = 1'b0; r1_write = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("init_addr",  32'(ram_addr), 32'(i));
      chk("init_we",    32'(ram_write_en), 1);
      chk("init_sel",   32'(ram_bank_sel), 1);
      chk("init_wdata", ram_write_data, 0);
      chk("init_rdy0",  32'(r0_ready), 0);
      chk("init_rdy1",  32'(r1_ready), 0);
      chk("init_done_lo", 32'(init_done), 0);
      step();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    settle();
    chk("init_done_hi", 32'(init_done), 1);
    chk("idle_sel",     32'(ram_bank_sel), 0);
    chk("idle_we",      32'(ram_write_en), 0);
    chk("init_rvalid0", 32'(r0_rvalid), 0);
  endtask

  initial begin
    int e0, e1;
    n_vec = 0; n_miss = 0;
    reset_n = 1'b0;
    r0_valid = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;

    // Reset state
    step(); step(); settle();
    chk("rst_sel",    32'(ram_bank_sel), 1);
    chk("rst_we",     32'(ram_write_en), 1);
    chk("rst_addr",   32'(ram_addr), 0);
    chk("rst_wdata",  ram_write_data, 0);
    chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 0);
    chk("rst_done",   32'(init_done), 0);
    reset_n = 1'b1;
    init_seq();

    // Cleared memory: r1 reads untouched addr 9 (RAM preset to garbage)
    step(); r1_valid = 1; r1_write = 0; r1_addr = 4'd9; settle();
    chk("clr_rdy1", 32'(r1_ready), 1);
    chk("clr_rdy0", 32'(r0_ready), 0);
    chk("clr_addr", 32'(ram_addr), 9);
    chk("clr_we",   32'(ram_write_en), 0);
    step(); r1_valid = 0; settle();
    chk("clr_rvalid1", 32'(r1_rvalid), 1);
    chk("clr_rdata",   r1_rdata, 0);
    chk("clr_rvalid0", 32'(r0_rvalid), 0);

    // Contention: last grant was r1, so r0 goes first and they alternate
    r0_addr = 4'd1; r1_addr = 4'd2; r0_write = 0; r1_write = 0;
    for (int k = 0; k < 6; k++) begin
      step(); r0_valid = 1; r1_valid = 1; settle();
      e0 = (k % 2 == 0) ? 1 : 0;
      e1 = 1 - e0;
      chk("rr_rdy0", 32'(r0_ready), e0);
      chk("rr_rdy1", 32'(r1_ready), e1);
      chk("rr_addr", 32'(ram_addr), (e0 == 1) ? 1 : 2);
      chk("rr_rv0",  32'(r0_rvalid), (k > 0 && e1 == 1) ? 1 : 0);
      chk("rr_rv1",  32'(r1_rvalid), (k > 0 && e0 == 1) ? 1 : 0);
    end
    step(); r0_valid = 0; r1_valid = 0; settle();
    chk("rr_tail_rv1", 32'(r1_rvalid), 1);
    chk("rr_tail_rv0", 32'(r0_rvalid), 0);

    // Basic write then read on r0
    step(); r0_valid = 1; r0_write = 1; r0_addr = 4'd3; r0_wdata = 32'hDEADBEEF; settle();
    chk("wr_rdy0",  32'(r0_ready), 1);
    chk("wr_we",    32'(ram_write_en), 1);
    chk("wr_addr",  32'(ram_addr), 3);
    chk("wr_wdata", ram_write_data, 32'hDEADBEEF);
    step(); r0_write = 0; settle();
    chk("rd_rdy0",     32'(r0_ready), 1);
    chk("wr_no_resp",  32'(r0_rvalid), 0);
    step(); r0_valid = 0; settle();
    chk("rd_rvalid0", 32'(r0_rvalid), 1);
    chk("rd_rdata0",  r0_rdata, 32'hDEADBEEF);
    chk("rd_rvalid1", 32'(r1_rvalid), 0);
    step(); settle();
    chk("rd_pulse", 32'(r0_rvalid), 0);

    // Cross-requester read-after-write
    step(); r0_valid = 1; r0_write = 1; r0_addr = 4'd5; r0_wdata = 32'h12345678; settle();
    chk("raw_rdy0", 32'(r0_ready), 1);
    step(); r0_valid = 0; r1_valid = 1; r1_write = 0; r1_addr = 4'd5; settle();
    chk("raw_rdy1", 32'(r1_ready), 1);
    step(); r1_valid = 0; settle();
    chk("raw_rvalid1", 32'(r1_rvalid), 1);
    chk("raw_rdata1",  r1_rdata, 32'h12345678);
    chk("raw_bcast0",  r0_rdata, 32'h12345678);
    chk("raw_rvalid0", 32'(r0_rvalid), 0);

    // Reset with a read in flight
    step(); r0_valid = 1; r0_write = 1; r0_addr = 4'd3; r0_wdata = 32'hA5A5A5A5; settle();
    chk("mr_wr_rdy", 32'(r0_ready), 1);
    step(); r0_write = 0; settle();
    chk("mr_rd_rdy", 32'(r0_ready), 1);
    @(posedge clock); #1; reset_n = 0; #1;
    chk("mr_rvalid", 32'(r0_rvalid), 0);
    chk("mr_done",   32'(init_done), 0);
    chk("mr_rdy",    32'(r0_ready), 0);
    chk("mr_we",     32'(ram_write_en), 1);
    chk("mr_addr",   32'(ram_addr), 0);
    step(); r0_valid = 0; settle();
    chk("mr_rvalid2", 32'(r0_rvalid), 0);
    reset_n = 1;
    init_seq();
    step(); r0_valid = 1; r0_write = 0; r0_addr = 4'd3; settle();
    chk("mr_rd2_rdy", 32'(r0_ready), 1);
    step(); r0_valid = 0; settle();
    chk("mr_rd2_rvalid", 32'(r0_rvalid), 1);
    chk("mr_rd2_rdata",  r0_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
